systolic_edge_feeder: RTL and testbench
=======================================

# systolic_edge_feeder

Upstream edge stage for the INT8 systolic multiply array. Accepts one N-lane operand vector per cycle from the tile buffer over a valid/ready handshake. Re-times it with a diagonal skew, so lane i reaches the array edge i cycles after lane 0, and drives the west-row or north-column inputs of the first PE row/column. One instance feeds rows and one feeds columns; both are started in the same cycle.

## Interface
- N, default 4: number of lanes, equal to the array dimension.
- DW, default 16: lane width, matching the PE row/column operand width.
- K_MAX, default 255: maximum vectors per tile (reduction depth).
- KW, default $clog2(K_MAX+1): width of k_len and the internal counters.
- clk, input, 1: clock.
- rst_n, input, 1: reset; asynchronous, active-low.
- start, input, 1: single-cycle pulse that launches a tile; ignored unless the state is IDLE.
- k_len, input, KW: number of vectors in the tile; sampled on an accepted start.
- in_valid, input, 1: upstream vector valid.
- in_ready, output, 1: feeder can accept a vector.
- in_data, input, N*DW: packed vector; lane i is bits [i*DW +: DW].
- edge_out, output, N*DW: skewed lanes driven to the PE edge inputs.
- edge_valid, output, N: lane i of edge_out carries accepted data.
- busy, output, 1: state is not IDLE.
- done, output, 1: single-cycle pulse when the tile has fully drained.
- underrun, output, 1: sticky flag set when a bubble was inserted during STREAM; cleared on the next accepted start.

## Operation
- States: IDLE, STREAM, FLUSH, DONE; the state type is feeder_state_t.
- IDLE, start=1:
  - Latch klen_q = min(k_len, K_MAX).
  - Clear the accept counter and underrun.
  - If klen_q != 0, go to STREAM; otherwise go to DONE.
- STREAM:
  - in_ready = 1.
  - Accept when in_valid && in_ready; increment acc_cnt on each accept.
  - On the accept that makes acc_cnt == klen_q, go to FLUSH.
  - A cycle in STREAM with in_valid=0 injects an all-zero vector with edge_valid lanes low, and sets underrun.
  - Zero operands contribute 0 to the PE MAC, so the partial sum is unaffected; the row/column alignment slips and is flagged.
- FLUSH:
  - in_ready = 0; zeros are shifted in.
  - A down-counter runs N-1 cycles, then the state goes to DONE.
  - When N=1, FLUSH lasts 0 cycles and STREAM goes directly to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Skew: lane i has a delay line of depth i plus one common output register.
  - Data is registered, never combinational from in_data.
  - edge_valid[i] travels alongside lane i's data.
- Outside accepted data, edge_out lanes are 0. The PE array therefore sees zeros whenever it is idle.
- start while busy is ignored: no state change and no relatch.

## Timing
- Reset values:
  - state = IDLE.
  - edge_out = 0, edge_valid = 0.
  - in_ready = 0, busy = 0, done = 0, underrun = 0.
  - All delay lines are cleared.
- Latency: a vector accepted at edge c appears on lane i during the cycle after edge c+i, i.e. latency 1+i.
- start accepted at edge s: in_ready = 1 from the cycle after s.
- The last accept at edge L:
  - makes FLUSH active cycles L+1 … L+N-1;
  - makes done high in cycle L+N, coincident with the last lane's last valid data;
  - makes busy low from cycle L+N+1.
- With k_len=0: done is high in the cycle after s and no edge_valid is raised.
- A new start is legal in the cycle after done, i.e. once IDLE is reached.
- Asynchronous reset mid-tile aborts immediately. All outputs return to their reset values and in-flight data is discarded.

## Configuration
- SYSTOLIC_FEEDER_UNDERRUN_CNT_EN defined:
  - Adds output underrun_cnt (16 bits), counting bubble cycles in the current tile.
  - It saturates at 16'hFFFF, is cleared on an accepted start, and resets to 0.
- Not defined: port and counter are absent; only the sticky underrun flag exists.

## Structure
- systolic_pkg holds:
  - the operand width constant (16) and the sum width constant (32), shared with pe;
  - feeder_state_t.
- Sub-module skew_delay_line, parameters DEPTH and DW:
  - carries a DW-bit data lane plus a valid bit through DEPTH registers, with async reset to 0;
  - when DEPTH=0 it is a wire.
- The feeder instantiates N skew_delay_line instances (lane i uses DEPTH=i), followed by one output register.

## Test plan
- Reset and basic skew:
  - Stimulus: N=4, start with k_len=3, in_valid held 1, vectors {lane0..3} = 1..4, 5..8, 9..12.
  - Response: lane 0 shows 1,5,9 from the cycle after the first accept; lane 3 shows 4,8,12 three cycles later.
  - done occurs in cycle L+4; underrun stays 0.
- Bubble:
  - Stimulus: k_len=2 with in_valid low for one cycle between the two vectors.
  - Response: one zero/invalid slot per lane between the vectors; underrun=1 (underrun_cnt=1 with the macro).
- Zero-length and clamp:
  - Stimulus: k_len=0, then k_len larger than K_MAX.
  - Response: for k_len=0, done is high the cycle after start with no edge_valid. For k_len > K_MAX, exactly K_MAX vectors are accepted.
- start while busy:
  - Stimulus: pulse start during STREAM with a different k_len.
  - Response: ignored; the original count completes.
- Reset mid-tile:
  - Stimulus: assert rst_n low during FLUSH.
  - Response: edge_out=0, edge_valid=0, busy=0 while asserted. After release, a fresh tile runs correctly.
- Backpressure/ready:
  - Check: in_ready is 0 in IDLE, FLUSH and DONE, so a valid vector presented then is not consumed.
  - Check: acc_cnt never exceeds klen_q.

Source files
------------

// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the INT8 systolic multiply array slice.
//   OPERAND_W      : PE row/column operand width (also the feeder lane width)
//   SUM_W          : PE accumulator width
//   feeder_state_t : control states of systolic_edge_feeder
// -----------------------------------------------------------------------------
package systolic_pkg;

    localparam int unsigned OPERAND_W = 16;
    localparam int unsigned SUM_W     = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/systolic_edge_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_edge_feeder_if
// Bundles the tile-control, upstream valid/ready and PE-edge signals of one
// systolic_edge_feeder instance.
//   master : tile buffer / sequencer side (drives start, k_len, in_valid, in_data)
//   slave  : the feeder (drives in_ready, edge_out, edge_valid, busy, done,
//            underrun and, with SYSTOLIC_FEEDER_UNDERRUN_CNT_EN, underrun_cnt)
// Optional feature macro: SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
// -----------------------------------------------------------------------------
interface systolic_edge_feeder_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 16,
    parameter int unsigned KW = 8
);

    logic              start;
    logic [KW-1:0]     k_len;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic [N*DW-1:0]   edge_out;
    logic [N-1:0]      edge_valid;
    logic              busy;
    logic              done;
    logic              underrun;
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
    logic [15:0]       underrun_cnt;

    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, edge_out, edge_valid, busy, done, underrun, underrun_cnt
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, edge_out, edge_valid, busy, done, underrun, underrun_cnt
    );
`else
    modport master (
        output start, k_len, in_valid, in_data,
        input  in_ready, edge_out, edge_valid, busy, done, underrun
    );

    modport slave (
        input  start, k_len, in_valid, in_data,
        output in_ready, edge_out, edge_valid, busy, done, underrun
    );
`endif

endinterface

// File: rtl/skew_delay_line.sv
// -----------------------------------------------------------------------------
// skew_delay_line
// Carries one DW-bit data lane plus its valid bit through DEPTH registers.
// DEPTH = 0 degenerates to a plain wire.
//   clk, rst_n           : clock, asynchronous active-low reset (clears to 0)
//   in_data, in_valid    : lane input
//   out_data, out_valid  : lane output, DEPTH cycles later
// -----------------------------------------------------------------------------
module skew_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic [DW-1:0] out_data,
    output logic          out_valid
);

    if (DEPTH == 0) begin : g_wire
        // Clock and reset are not needed by a zero-depth lane.
        logic unused_clk_rst_s;
        assign unused_clk_rst_s = clk ^ rst_n;
        assign out_data  = in_data;
        assign out_valid = in_valid;
    end else begin : g_pipe
        logic [DEPTH-1:0][DW-1:0] data_r;
        logic [DEPTH-1:0]         valid_r;

        // Shift register: stage 0 takes the input, each later stage the previous one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_r  <= '0;
                valid_r <= '0;
            end else begin
                data_r[0]  <= in_data;
                valid_r[0] <= in_valid;
                for (int k = 1; k < DEPTH; k++) begin
                    data_r[k]  <= data_r[k-1];
                    valid_r[k] <= valid_r[k-1];
                end
            end
        end

        assign out_data  = data_r[DEPTH-1];
        assign out_valid = valid_r[DEPTH-1];
    end

endmodule

// File: rtl/systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// systolic_edge_feeder
// Upstream edge stage of the systolic array. Accepts k_len N-lane vectors per
// tile over valid/ready and skews them diagonally so lane i reaches the PE edge
// i cycles after lane 0 (latency 1+i from the accepting edge).
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.start, bus.k_len       : tile launch (accepted in IDLE only)
//   bus.in_valid/in_ready/in_data : upstream vector handshake
//   bus.edge_out, bus.edge_valid  : skewed lanes to the PE edge (0 when idle)
//   bus.busy, bus.done, bus.underrun : status
// Optional feature macro: SYSTOLIC_FEEDER_UNDERRUN_CNT_EN adds bus.underrun_cnt,
// a saturating per-tile count of bubble cycles.
// -----------------------------------------------------------------------------
module systolic_edge_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned DW    = OPERAND_W,
    parameter int unsigned K_MAX = 255,
    parameter int unsigned KW    = $clog2(K_MAX + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    systolic_edge_feeder_if.slave bus
);

    // FLUSH lasts N-1 cycles: the counter is loaded with N-2 and runs to 0.
    localparam int unsigned FW         = (N > 2) ? $clog2(N - 1) : 1;
    localparam int unsigned FLUSH_LOAD = (N > 1) ? (N - 2) : 0;

    feeder_state_t   state_r;
    feeder_state_t   state_s;

    logic [KW-1:0]   klen_q_r;
    logic [KW-1:0]   acc_cnt_r;
    logic [KW-1:0]   klen_clamp_s;
    logic [FW-1:0]   flush_cnt_r;

    logic            start_acc_s;
    logic            accept_s;
    logic            bubble_s;
    logic            last_acc_s;

    logic            in_ready_s;
    logic            busy_s;
    logic            done_s;
    logic            in_ready_r;
    logic            busy_r;
    logic            done_r;
    logic            underrun_r;

    logic [N*DW-1:0] dl_data_s;
    logic [N-1:0]    dl_valid_s;
    logic [N*DW-1:0] edge_out_r;
    logic [N-1:0]    edge_valid_r;

    // Handshake qualifiers and k_len clamp.
    always_comb begin
        start_acc_s = bus.start && (state_r == IDLE);
        accept_s    = (state_r == STREAM) && bus.in_valid && in_ready_r;
        bubble_s    = (state_r == STREAM) && !bus.in_valid;
        last_acc_s  = accept_s && ((acc_cnt_r + KW'(1)) == klen_q_r);
        if (bus.k_len > KW'(K_MAX)) begin
            klen_clamp_s = KW'(K_MAX);
        end else begin
            klen_clamp_s = bus.k_len;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_acc_s) begin
                    if (klen_clamp_s != {KW{1'b0}}) begin
                        state_s = STREAM;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            STREAM: begin
                if (last_acc_s) begin
                    // A single-lane feeder has nothing left in flight to drain.
                    if (N > 1) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = STREAM;
                end
            end
            FLUSH: begin
                if (flush_cnt_r == {FW{1'b0}}) begin
                    state_s = DONE;
                end else begin
                    state_s = FLUSH;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Output decode from the next state so the status outputs come straight from flops.
    always_comb begin
        in_ready_s = (state_s == STREAM);
        busy_s     = (state_s != IDLE);
        done_s     = (state_s == DONE);
    end

    // Status output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

    // Tile length latch and accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klen_q_r  <= {KW{1'b0}};
            acc_cnt_r <= {KW{1'b0}};
        end else if (start_acc_s) begin
            klen_q_r  <= klen_clamp_s;
            acc_cnt_r <= {KW{1'b0}};
        end else if (accept_s) begin
            acc_cnt_r <= acc_cnt_r + KW'(1);
        end else begin
            acc_cnt_r <= acc_cnt_r;
        end
    end

    // FLUSH down-counter, loaded on the STREAM to FLUSH transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_cnt_r <= {FW{1'b0}};
        end else if ((state_r == STREAM) && (state_s == FLUSH)) begin
            flush_cnt_r <= FW'(FLUSH_LOAD);
        end else if ((state_r == FLUSH) && (flush_cnt_r != {FW{1'b0}})) begin
            flush_cnt_r <= flush_cnt_r - FW'(1);
        end else begin
            flush_cnt_r <= flush_cnt_r;
        end
    end

    // Sticky underrun flag: a STREAM cycle without upstream data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_r <= 1'b0;
        end else if (start_acc_s) begin
            underrun_r <= 1'b0;
        end else if (bubble_s) begin
            underrun_r <= 1'b1;
        end else begin
            underrun_r <= underrun_r;
        end
    end

`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating per-tile bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt_r <= 16'h0000;
        end else if (start_acc_s) begin
            underrun_cnt_r <= 16'h0000;
        end else if (bubble_s && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'h0001;
        end else begin
            underrun_cnt_r <= underrun_cnt_r;
        end
    end

    assign bus.underrun_cnt = underrun_cnt_r;
`endif

    // Per-lane skew. Anything that is not an accepted vector enters as zero with
    // valid low, so bubbles and flush slots present zero operands to the PEs.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [DW-1:0] lane_in_s;
        assign lane_in_s = accept_s ? bus.in_data[i*DW +: DW] : {DW{1'b0}};

        skew_delay_line #(
            .DEPTH (i),
            .DW    (DW)
        ) u_delay (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_data   (lane_in_s),
            .in_valid  (accept_s),
            .out_data  (dl_data_s[i*DW +: DW]),
            .out_valid (dl_valid_s[i])
        );
    end

    // Common output register in front of the PE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_out_r   <= {(N*DW){1'b0}};
            edge_valid_r <= {N{1'b0}};
        end else begin
            edge_out_r   <= dl_data_s;
            edge_valid_r <= dl_valid_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.underrun   = underrun_r;
    assign bus.edge_out   = edge_out_r;
    assign bus.edge_valid = edge_valid_r;

endmodule

// File: tb/tb_systolic_edge_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_edge_feeder
// Directed bench for systolic_edge_feeder with N=4, DW=16, K_MAX=5 (KW=3, so
// k_len values above K_MAX can be driven). Expected per-cycle edge patterns
// are hand-derived tables; k=0 is the cycle right after the start edge.
// -----------------------------------------------------------------------------
module tb_systolic_edge_feeder;

    localparam int unsigned N     = 4;
    localparam int unsigned DW    = 16;
    localparam int unsigned K_MAX = 5;
    localparam int unsigned KW    = 3;
    localparam int          TMAX  = 12;

    logic clk = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_edge_feeder_if #(.N(N), .DW(DW), .KW(KW)) bus ();

    systolic_edge_feeder #(
        .N     (N),
        .DW    (DW),
        .K_MAX (K_MAX),
        .KW    (KW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stimulus and expectation tables for one tile.
    logic        tv_valid [TMAX];
    logic [63:0] tv_data  [TMAX];
    logic [3:0]  te_valid [TMAX];
    logic [63:0] te_data  [TMAX];
    logic        te_done  [TMAX];
    logic        te_busy  [TMAX];
    logic        te_ready [TMAX];
    int          t_len;

    localparam logic [63:0] JUNK = 64'hAAAA_AAAA_AAAA_AAAA;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                          input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tables();
        for (int k = 0; k < TMAX; k++) begin
            tv_valid[k] = 1'b0;
            tv_data[k]  = 64'h0;
            te_valid[k] = 4'h0;
            te_data[k]  = 64'h0;
            te_done[k]  = 1'b0;
            te_busy[k]  = 1'b0;
            te_ready[k] = 1'b0;
        end
        t_len = 0;
    endtask

    // k_len=3, vectors 1..4, 5..8, 9..12 back to back; junk offered during FLUSH/DONE/IDLE.
    task automatic fill_skew();
        clear_tables();
        t_len = 8;
        tv_valid[0] = 1'b1; tv_data[0] = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        tv_valid[1] = 1'b1; tv_data[1] = pack4(16'd5, 16'd6, 16'd7, 16'd8);
        tv_valid[2] = 1'b1; tv_data[2] = pack4(16'd9, 16'd10, 16'd11, 16'd12);
        for (int k = 3; k < 8; k++) begin
            tv_valid[k] = 1'b1;
            tv_data[k]  = JUNK;
        end
        te_valid[1] = 4'h1; te_data[1] = pack4(16'd1,  16'd0,  16'd0,  16'd0);
        te_valid[2] = 4'h3; te_data[2] = pack4(16'd5,  16'd2,  16'd0,  16'd0);
        te_valid[3] = 4'h7; te_data[3] = pack4(16'd9,  16'd6,  16'd3,  16'd0);
        te_valid[4] = 4'hE; te_data[4] = pack4(16'd0,  16'd10, 16'd7,  16'd4);
        te_valid[5] = 4'hC; te_data[5] = pack4(16'd0,  16'd0,  16'd11, 16'd8);
        te_valid[6] = 4'h8; te_data[6] = pack4(16'd0,  16'd0,  16'd0,  16'd12);
        te_done[6] = 1'b1;
        for (int k = 0; k <= 6; k++) te_busy[k] = 1'b1;
        for (int k = 0; k <= 2; k++) te_ready[k] = 1'b1;
    endtask

    task automatic run_table(input string tag, input logic [KW-1:0] klen);
        bus.k_len    = klen;
        bus.start    = 1'b1;
        bus.in_valid = tv_valid[0];
        bus.in_data  = tv_data[0];
        step();
        bus.start = 1'b0;
        for (int k = 0; k < t_len; k++) begin
            check_eq($sformatf("%s.edge_valid@%0d", tag, k), 64'(bus.edge_valid), 64'(te_valid[k]));
            check_eq($sformatf("%s.edge_out@%0d", tag, k), bus.edge_out, te_data[k]);
            check_eq($sformatf("%s.done@%0d", tag, k), 64'(bus.done), 64'(te_done[k]));
            check_eq($sformatf("%s.busy@%0d", tag, k), 64'(bus.busy), 64'(te_busy[k]));
            check_eq($sformatf("%s.in_ready@%0d", tag, k), 64'(bus.in_ready), 64'(te_ready[k]));
            bus.in_valid = tv_valid[k];
            bus.in_data  = tv_data[k];
            step();
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 64'h0;
    endtask

    // Tile with in_valid held high; optionally pulses start (k_len=5) at cycle busy_k.
    task automatic run_count(input string tag, input logic [KW-1:0] klen, input int busy_k,
                             input int exp_acc, input int exp_done_k);
        int n0;
        int n3;
        int done_k;
        n0 = 0;
        n3 = 0;
        done_k = -1;
        bus.k_len    = klen;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        step();
        bus.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.edge_valid[0]) n0++;
            if (bus.edge_valid[3]) n3++;
            if (bus.done && (done_k < 0)) done_k = k;
            bus.start = (k == busy_k);
            bus.k_len = (k == busy_k) ? 3'd5 : klen;
            step();
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq({tag, ".lane0_vectors"}, 64'(n0), 64'(exp_acc));
        check_eq({tag, ".lane3_vectors"}, 64'(n3), 64'(exp_acc));
        check_eq({tag, ".done_cycle"}, 64'(done_k), 64'(exp_done_k));
        check_eq({tag, ".busy_end"}, 64'(bus.busy), 64'h0);
        check_eq({tag, ".underrun"}, 64'(bus.underrun), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.k_len    = 3'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'h0;
        #2;
        check_eq("rst.edge_valid", 64'(bus.edge_valid), 64'h0);
        check_eq("rst.edge_out", bus.edge_out, 64'h0);
        check_eq("rst.in_ready", 64'(bus.in_ready), 64'h0);
        check_eq("rst.busy", 64'(bus.busy), 64'h0);
        check_eq("rst.done", 64'(bus.done), 64'h0);
        check_eq("rst.underrun", 64'(bus.underrun), 64'h0);
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
        check_eq("rst.underrun_cnt", 64'(bus.underrun_cnt), 64'h0);
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

        // A valid vector offered in IDLE must not be consumed.
        bus.in_valid = 1'b1;
        bus.in_data  = JUNK;
        step();
        check_eq("idle.in_ready", 64'(bus.in_ready), 64'h0);
        check_eq("idle.edge_valid", 64'(bus.edge_valid), 64'h0);

        fill_skew();
        run_table("skew", 3'd3);
        check_eq("skew.underrun", 64'(bus.underrun), 64'h0);

        // Bubble between two vectors.
        clear_tables();
        t_len = 8;
        tv_valid[0] = 1'b1; tv_data[0] = pack4(16'hA0, 16'hA1, 16'hA2, 16'hA3);
        tv_valid[1] = 1'b0; tv_data[1] = JUNK;
        tv_valid[2] = 1'b1; tv_data[2] = pack4(16'hB0, 16'hB1, 16'hB2, 16'hB3);
        te_valid[1] = 4'h1; te_data[1] = pack4(16'hA0, 16'h0,  16'h0,  16'h0);
        te_valid[2] = 4'h2; te_data[2] = pack4(16'h0,  16'hA1, 16'h0,  16'h0);
        te_valid[3] = 4'h5; te_data[3] = pack4(16'hB0, 16'h0,  16'hA2, 16'h0);
        te_valid[4] = 4'hA; te_data[4] = pack4(16'h0,  16'hB1, 16'h0,  16'hA3);
        te_valid[5] = 4'h4; te_data[5] = pack4(16'h0,  16'h0,  16'hB2, 16'h0);
        te_valid[6] = 4'h8; te_data[6] = pack4(16'h0,  16'h0,  16'h0,  16'hB3);
        te_done[6] = 1'b1;
        for (int k = 0; k <= 6; k++) te_busy[k] = 1'b1;
        for (int k = 0; k <= 2; k++) te_ready[k] = 1'b1;
        run_table("bubble", 3'd2);
        check_eq("bubble.underrun", 64'(bus.underrun), 64'h1);
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
        check_eq("bubble.underrun_cnt", 64'(bus.underrun_cnt), 64'h1);
`endif

        // Zero-length tile: done the cycle after start, nothing emitted, underrun cleared.
        clear_tables();
        t_len = 4;
        for (int k = 0; k < 4; k++) begin
            tv_valid[k] = 1'b1;
            tv_data[k]  = JUNK;
        end
        te_done[0] = 1'b1;
        te_busy[0] = 1'b1;
        run_table("zero_len", 3'd0);
        check_eq("zero_len.underrun", 64'(bus.underrun), 64'h0);
`ifdef SYSTOLIC_FEEDER_UNDERRUN_CNT_EN
        check_eq("zero_len.underrun_cnt", 64'(bus.underrun_cnt), 64'h0);
`endif

        // k_len=7 clamps to K_MAX=5: last accept at s+5, done at k=8.
        run_count("clamp", 3'd7, -1, 5, 8);

        // start with k_len=5 during STREAM is ignored: 2 vectors, done at k=5.
        run_count("start_busy", 3'd2, 1, 2, 5);

        // Reset during FLUSH.
        bus.k_len    = 3'd2;
        bus.start    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = pack4(16'd1, 16'd2, 16'd3, 16'd4);
        step();
        bus.start = 1'b0;
        step();
        step();
        check_eq("midrst.pre_busy", 64'(bus.busy), 64'h1);
        check_eq("midrst.pre_in_ready", 64'(bus.in_ready), 64'h0);
        check_eq("midrst.pre_edge_valid", 64'(bus.edge_valid), 64'h3);
        rst_n = 1'b0;
        #2;
        check_eq("midrst.edge_valid", 64'(bus.edge_valid), 64'h0);
        check_eq("midrst.edge_out", bus.edge_out, 64'h0);
        check_eq("midrst.busy", 64'(bus.busy), 64'h0);
        check_eq("midrst.done", 64'(bus.done), 64'h0);
        step();
        check_eq("midrst.held_edge_valid", 64'(bus.edge_valid), 64'h0);
        check_eq("midrst.held_busy", 64'(bus.busy), 64'h0);
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        fill_skew();
        run_table("after_rst", 3'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
